moesif_snoopy_bus_controller: RTL and testbench

// Bus-side counterpart of the per-cache MOESIF protocol logic. Arbitrates bus requests from

---
 rtl/moesif_snoopy_bus_controller_pkg.sv | 25 ++
 rtl/moesif_snoopy_bus_controller_round_robin_arbiter.sv | 37 +++
 rtl/moesif_snoopy_bus_controller.sv | 180 ++++++++++++++++++
 tb/tb_moesif_snoopy_bus_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/moesif_snoopy_bus_controller_pkg.sv
// Shared types for the MOESIF snoopy bus controller: bus commands and FSM states.
package moesif_snoopy_bus_controller_pkg;

  typedef enum logic [1:0] {
    BUS_READ           = 2'd0,
    BUS_READ_EXCLUSIVE = 2'd1,
    BUS_INVALIDATE     = 2'd2,
    BUS_WRITEBACK      = 2'd3
  } bus_command_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GRANT       = 3'd1,
    SNOOP       = 3'd2,
    DATA_CACHE  = 3'd3,
    DATA_MEMORY = 3'd4,
    FINISH      = 3'd5
  } bus_state_t;

  // True for commands that fetch the line into the requester.
  function automatic logic is_line_fetch(input bus_command_t cmd);
    return (cmd == BUS_READ) || (cmd == BUS_READ_EXCLUSIVE);
  endfunction

endpackage

// File: rtl/moesif_snoopy_bus_controller_round_robin_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer, wrapping.
module round_robin_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  // Scan requests starting at the pointer and keep the first hit.
  always_comb begin
    int  k;
    logic found_s;
    grant   = '0;
    index   = '0;
    found_s = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(pointer) + i;
      if (k >= N) begin
        k = k - N;
      end else begin
        k = k;
      end
      if (!found_s && request[k]) begin
        found_s  = 1'b1;
        grant[k] = 1'b1;
        index    = IW'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/moesif_snoopy_bus_controller.sv
// MOESIF snoopy bus controller: arbitrates caches, broadcasts snoops, sources line data.
module moesif_snoopy_bus_controller
  import moesif_snoopy_bus_controller_pkg::*;
#(
  parameter int NUMBER_OF_CACHES = 4,
  parameter int ADDRESS_WIDTH    = 16,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUMBER_OF_CACHES-1:0]             busRequest,
  input  logic [NUMBER_OF_CACHES*2-1:0]           busCommand,
  input  logic [NUMBER_OF_CACHES*ADDRESS_WIDTH-1:0] busAddress,
  input  logic [NUMBER_OF_CACHES*DATA_WIDTH-1:0]  busDataIn,
  output logic [NUMBER_OF_CACHES-1:0]             grant,
  output logic [NUMBER_OF_CACHES-1:0]             done,
  output logic [1:0]                              commandOut,
  output logic [ADDRESS_WIDTH-1:0]                addressOut,
  output logic [NUMBER_OF_CACHES-1:0]             snoopValid,
  input  logic [NUMBER_OF_CACHES-1:0]             sharedOutIn,
  input  logic [NUMBER_OF_CACHES-1:0]             ownedOutIn,
  input  logic [NUMBER_OF_CACHES-1:0]             supplyIn,
  output logic                                    sharedIn,
  output logic                                    ownedIn,
  output logic [DATA_WIDTH-1:0]                   dataOut,
  output logic                                    memRead,
  output logic                                    memWrite,
  output logic [ADDRESS_WIDTH-1:0]                memAddress,
  output logic [DATA_WIDTH-1:0]                   memDataOut,
  input  logic [DATA_WIDTH-1:0]                   memDataIn,
  input  logic                                    memAck
);

  localparam int N  = NUMBER_OF_CACHES;
  localparam int IW = $clog2(N);

  bus_state_t               state_r, state_next_s;
  bus_command_t             cmd_r;
  logic [IW-1:0]            req_idx_r, pointer_r, supplier_r;
  logic [ADDRESS_WIDTH-1:0] addr_r, mem_addr_r;
  logic [DATA_WIDTH-1:0]    data_r, mem_data_r;
  logic                     shared_r, owned_r;
  logic [N-1:0]             arb_grant_s, req_onehot_s;
  logic [IW-1:0]            arb_index_s, supplier_s;
  logic                     supplier_found_s;
  logic [N-1:0]             one_s;

  assign one_s        = {{(N-1){1'b0}}, 1'b1};
  assign req_onehot_s = one_s << req_idx_r;

  round_robin_arbiter #(.N(N), .IW(IW)) u_arbiter (
    .request (busRequest),
    .pointer (pointer_r),
    .grant   (arb_grant_s),
    .index   (arb_index_s)
  );

  // Lowest-index non-requester holding the line supplies it.
  always_comb begin
    supplier_s       = '0;
    supplier_found_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (supplyIn[i] && !req_onehot_s[i]) begin
        supplier_found_s = 1'b1;
        supplier_s       = IW'(i);
      end else begin
        supplier_found_s = supplier_found_s;
      end
    end
  end

  // Transaction sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:        if (|arb_grant_s) state_next_s = GRANT; else state_next_s = IDLE;
      GRANT:       if (cmd_r == BUS_WRITEBACK) state_next_s = DATA_MEMORY; else state_next_s = SNOOP;
      SNOOP: begin
        if (cmd_r == BUS_INVALIDATE)  state_next_s = FINISH;
        else if (supplier_found_s)    state_next_s = DATA_CACHE;
        else                          state_next_s = DATA_MEMORY;
      end
      DATA_CACHE:  state_next_s = FINISH;
      DATA_MEMORY: if (memAck) state_next_s = FINISH; else state_next_s = DATA_MEMORY;
      FINISH:      state_next_s = IDLE;
      default:     state_next_s = IDLE;
    endcase
  end

  // State register; reset aborts any transaction at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Transaction datapath: latch request, snoop responses, line data and pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_r      <= BUS_READ;
      req_idx_r  <= '0;
      pointer_r  <= '0;
      supplier_r <= '0;
      addr_r     <= '0;
      mem_addr_r <= '0;
      data_r     <= '0;
      mem_data_r <= '0;
      shared_r   <= 1'b0;
      owned_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|arb_grant_s) begin
            req_idx_r <= arb_index_s;
            cmd_r     <= bus_command_t'(busCommand[int'(arb_index_s)*2 +: 2]);
            addr_r    <= busAddress[int'(arb_index_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          end
        end
        GRANT: begin
          if (cmd_r == BUS_WRITEBACK) begin
            mem_addr_r <= addr_r;
            mem_data_r <= busDataIn[int'(req_idx_r)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        SNOOP: begin
          shared_r   <= |(sharedOutIn & ~req_onehot_s);
          owned_r    <= |(ownedOutIn & ~req_onehot_s);
          supplier_r <= supplier_s;
          if (is_line_fetch(cmd_r) && !supplier_found_s) begin
            mem_addr_r <= addr_r;
            mem_data_r <= busDataIn[int'(req_idx_r)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        DATA_CACHE:  data_r <= busDataIn[int'(supplier_r)*DATA_WIDTH +: DATA_WIDTH];
        DATA_MEMORY: if (memAck && cmd_r != BUS_WRITEBACK) data_r <= memDataIn;
        FINISH: begin
          if (int'(req_idx_r) == N - 1) pointer_r <= '0;
          else                          pointer_r <= req_idx_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus and memory strobes decoded from the registered state.
  always_comb begin
    grant      = '0;
    done       = '0;
    snoopValid = '0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    case (state_r)
      IDLE: grant = '0;
      GRANT: begin
        grant = req_onehot_s;
        if (cmd_r != BUS_WRITEBACK) snoopValid = ~req_onehot_s;
        else                        snoopValid = '0;
      end
      SNOOP, DATA_CACHE: grant = req_onehot_s;
      DATA_MEMORY: begin
        grant    = req_onehot_s;
        memRead  = (cmd_r != BUS_WRITEBACK);
        memWrite = (cmd_r == BUS_WRITEBACK);
      end
      FINISH: begin
        grant = req_onehot_s;
        done  = req_onehot_s;
      end
      default: grant = '0;
    endcase
  end

  assign commandOut = cmd_r;
  assign addressOut = addr_r;
  assign sharedIn   = shared_r;
  assign ownedIn    = owned_r;
  assign dataOut    = data_r;
  assign memAddress = mem_addr_r;
  assign memDataOut = mem_data_r;

endmodule

// File: tb/tb_moesif_snoopy_bus_controller.sv
// Scoreboard bench for the MOESIF snoopy bus controller.
module tb_moesif_snoopy_bus_controller;
  import moesif_snoopy_bus_controller_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    busRequest, grant, done, snoopValid, sharedOutIn, ownedOutIn, supplyIn;
  logic [N*2-1:0]  busCommand;
  logic [N*AW-1:0] busAddress;
  logic [N*DW-1:0] busDataIn;
  logic [1:0]      commandOut;
  logic [AW-1:0]   addressOut, memAddress;
  logic            sharedIn, ownedIn, memRead, memWrite, memAck;
  logic [DW-1:0]   dataOut, memDataOut, memDataIn;

  moesif_snoopy_bus_controller #(.NUMBER_OF_CACHES(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .busRequest(busRequest), .busCommand(busCommand),
    .busAddress(busAddress), .busDataIn(busDataIn), .grant(grant), .done(done),
    .commandOut(commandOut), .addressOut(addressOut), .snoopValid(snoopValid),
    .sharedOutIn(sharedOutIn), .ownedOutIn(ownedOutIn), .supplyIn(supplyIn),
    .sharedIn(sharedIn), .ownedIn(ownedIn), .dataOut(dataOut), .memRead(memRead),
    .memWrite(memWrite), .memAddress(memAddress), .memDataOut(memDataOut),
    .memDataIn(memDataIn), .memAck(memAck)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [1:0]  cmd;
    logic [AW-1:0] addr;
    logic        chk_data;
    logic [DW-1:0] data;
    logic        chk_snoop;
    logic        shared;
    logic        owned;
    logic [N-1:0] snoop;
    int          mem_kind;   // 0 none, 1 read, 2 write
    logic [DW-1:0] mem_data;
    int          latency;    // negedges from request to done, or -1
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            mem_delay = 3;
  logic [DW-1:0] mem_value = 32'h12345678;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int idx, input logic [1:0] cmd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    busRequest[idx]             = 1'b1;
    busCommand[idx*2 +: 2]      = cmd;
    busAddress[idx*AW +: AW]    = addr;
    busDataIn[idx*DW +: DW]     = wdata;
  endtask

  task automatic expect_txn(input int idx, input logic [1:0] cmd, input logic [AW-1:0] addr,
                            input logic chk_data, input logic [DW-1:0] data,
                            input logic chk_snoop, input logic shared, input logic owned,
                            input int mem_kind, input logic [DW-1:0] mem_data, input int latency);
    exp_t e;
    e.idx = idx; e.cmd = cmd; e.addr = addr; e.chk_data = chk_data; e.data = data;
    e.chk_snoop = chk_snoop; e.shared = shared; e.owned = owned;
    e.snoop = (cmd == BUS_WRITEBACK) ? 4'b0000 : ~(4'b0001 << idx);
    e.mem_kind = mem_kind; e.mem_data = mem_data; e.latency = latency;
    sb.push_back(e);
  endtask

  // Run the bus until one done pulse, acting as memory, then score it against the queue front.
  task automatic serve(input int budget);
    int          cyc = 0;
    int          mcount = 0;
    logic        got = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [N-1:0] snoop_or = '0;
    exp_t        e;
    while (!got && cyc < budget) begin
      @(negedge clock);
      cyc++;
      snoop_or |= snoopValid;
      rd |= memRead;
      wr |= memWrite;
      if (memRead || memWrite) begin
        mcount++;
        if (mcount == mem_delay) begin
          memAck    = 1'b1;
          memDataIn = mem_value;
          if (sb.size() > 0) begin
            check_value("mem_address", memAddress, sb[0].addr);
            if (memWrite) check_value("mem_data_out", memDataOut, sb[0].mem_data);
          end
        end else begin
          memAck = 1'b0;
        end
      end else begin
        memAck = 1'b0;
        mcount = 0;
      end
      if (done != '0) got = 1'b1;
    end
    memAck = 1'b0;
    if (!got) begin
      check_value("done_timeout", 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      check_value("unexpected_done", done, 64'd0);
    end else begin
      e = sb.pop_front();
      check_value("done_onehot", done, 4'b0001 << e.idx);
      check_value("grant_in_finish", grant, 4'b0001 << e.idx);
      check_value("command_out", commandOut, e.cmd);
      check_value("address_out", addressOut, e.addr);
      check_value("snoop_valid", snoop_or, e.snoop);
      check_value("mem_read_seen", rd, e.mem_kind == 1);
      check_value("mem_write_seen", wr, e.mem_kind == 2);
      if (e.chk_data)  check_value("data_out", dataOut, e.data);
      if (e.chk_snoop) check_value("shared_in", sharedIn, e.shared);
      if (e.chk_snoop) check_value("owned_in", ownedIn, e.owned);
      if (e.latency > 0) check_value("latency", cyc, e.latency);
      busRequest = busRequest & ~done;
    end
  endtask

  initial begin
    reset = 1'b1;
    busRequest = '0; busCommand = '0; busAddress = '0; busDataIn = '0;
    sharedOutIn = '0; ownedOutIn = '0; supplyIn = '0; memDataIn = '0; memAck = 1'b0;
    repeat (2) @(negedge clock);
    check_value("rst_grant", grant, 4'b0000);
    check_value("rst_done", done, 4'b0000);
    check_value("rst_snoop", snoopValid, 4'b0000);
    check_value("rst_mem_strobes", {memRead, memWrite}, 2'b00);
    check_value("rst_shared_owned", {sharedIn, ownedIn}, 2'b00);
    check_value("rst_command", commandOut, BUS_READ);
    check_value("rst_addresses", {addressOut, memAddress}, 32'h0);
    check_value("rst_data", {dataOut, memDataOut}, 64'h0);
    reset = 1'b0;
    @(negedge clock);

    // Reset in the middle of a memory read drops the strobe immediately.
    raise(0, BUS_READ, 16'h0100, 32'h0);
    for (int i = 0; i < 20 && !memRead; i++) @(negedge clock);
    check_value("mem_read_before_reset", memRead, 1'b1);
    #1 reset = 1'b1;
    #1 check_value("mem_read_async_drop", memRead, 1'b0);
    check_value("grant_async_drop", grant, 4'b0000);
    busRequest = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_value("grant_after_reset", grant, 4'b0000);
    check_value("done_after_reset", done, 4'b0000);

    // Cache1 read supplied by cache2; requester's own response lines are masked.
    sharedOutIn = 4'b0010; ownedOutIn = 4'b0100; supplyIn = 4'b0110;
    raise(2, BUS_READ, 16'h0000, 32'hCAFE0002);
    busRequest[2] = 1'b0;
    raise(1, BUS_READ, 16'h0222, 32'h11111111);
    expect_txn(1, BUS_READ, 16'h0222, 1'b1, 32'hCAFE0002, 1'b1, 1'b0, 1'b1, 0, 32'h0, 4);
    serve(40);
    @(negedge clock);

    // Cache0 read from memory, no supplier.
    sharedOutIn = 4'b0000; ownedOutIn = 4'b0000; supplyIn = 4'b0000;
    mem_value = 32'h12345678;
    raise(0, BUS_READ, 16'h0310, 32'h0);
    expect_txn(0, BUS_READ, 16'h0310, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1, 32'h0, 3 + mem_delay);
    serve(40);
    @(negedge clock);

    // Cache3 invalidate: even with a supplier present no data phase happens.
    sharedOutIn = 4'b0001; supplyIn = 4'b0001;
    raise(3, BUS_INVALIDATE, 16'h0040, 32'h0);
    expect_txn(3, BUS_INVALIDATE, 16'h0040, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 32'h0, 3);
    serve(40);
    @(negedge clock);

    // Cache2 write-back straight to memory.
    sharedOutIn = 4'b0000; supplyIn = 4'b0000;
    raise(2, BUS_WRITEBACK, 16'h1230, 32'hA5A5A5A5);
    expect_txn(2, BUS_WRITEBACK, 16'h1230, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 32'hA5A5A5A5, 2 + mem_delay);
    serve(40);
    @(negedge clock);

    // Fresh pointer, all four request; cache0 re-requests and waits behind 1,2,3.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mem_delay = 1;
    for (int i = 0; i < N; i++) begin
      mem_value = 32'h0;
      raise(i, BUS_READ_EXCLUSIVE, 16'h0500 + 16'(i), 32'h0);
      expect_txn(i, BUS_READ_EXCLUSIVE, 16'h0500 + 16'(i), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 32'h0, -1);
    end
    mem_value = 32'h5EED0000;
    serve(40);
    raise(0, BUS_READ, 16'h0600, 32'h0);
    expect_txn(0, BUS_READ, 16'h0600, 1'b1, 32'h5EED0000, 1'b1, 1'b0, 1'b0, 1, 32'h0, -1);
    for (int i = 0; i < N; i++) serve(40);
    check_value("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
